serial_subtractor: RTL and testbench

//   Bit-serial subtractor: computes diff = a - b one bit per clock, LSB first.

---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             ovf;

   modport master (output start, a, b, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, input busy, done, diff, bout);
   modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock with a registered borrow.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bout_q, bout_d;
   logic             ai, bi, d_bit, borrow_n;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      ai       = a_sr_q[0];
      bi       = b_sr_q[0];
      d_bit    = ai ^ bi ^ borrow_q;
      borrow_n = (~ai & bi) | (~(ai ^ bi) & borrow_q);

      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      bout_d   = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_d    = ovf_q;
`endif

      unique case (state_q)
         // DONE accepts start exactly like IDLE so jobs can run back to back.
         StIdle, StDone: begin
            if (bus.start) begin
               state_d  = StRun;
               busy_d   = 1'b1;
               a_sr_d   = bus.a;
               b_sr_d   = bus.b;
               diff_d   = '0;
               cnt_d    = '0;
               borrow_d = 1'b0;
               bout_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
               ovf_d    = 1'b0;
`endif
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            busy_d   = 1'b1;
            diff_d   = {d_bit, diff_q[WIDTH-1:1]};
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            borrow_d = borrow_n;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bout_d  = borrow_n;
`ifdef SERIAL_SUB_OVERFLOW_EN
               // On the MSB cycle ai/bi are the operand sign bits.
               ovf_d   = (ai != bi) && (d_bit != ai);
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed vector table plus corner-case sequences for serial_subtractor,
// and back-to-back random jobs on WIDTH = 2, 8 and 33 instances.
module tb_serial_subtractor;
   localparam int unsigned W = 8;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   serial_subtractor_if #(.WIDTH(W)) bus ();
   serial_subtractor #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Launch one job from idle; report edges from accept to done and busy-cycle count.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat,
                        output int busy_n, output logic [W-1:0] diff_acc);
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = ~av;
      bus.b     = ~bv;
      diff_acc  = bus.diff;
      busy_n    = bus.busy ? 1 : 0;
      lat       = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy) busy_n++;
         if (bus.done) break;
      end
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } vec_t;

   vec_t vecs[8];

   // Random back-to-back jobs with start held high, one instance per width.
   for (genvar g = 0; g < 3; g++) begin : g_rand
      localparam int unsigned RW = (g == 0) ? 2 : ((g == 1) ? 8 : 33);
      logic wrst;
      logic fin = 1'b0;
      serial_subtractor_if #(.WIDTH(RW)) rbus ();
      serial_subtractor #(.WIDTH(RW)) u_dut (.clk(clk), .rst(wrst), .bus(rbus));

      initial begin
         logic [RW-1:0] ea[8];
         logic [RW-1:0] eb[8];
         int k, last, cyc;
         wrst       = 1'b1;
         rbus.start = 1'b0;
         rbus.a     = '0;
         rbus.b     = '0;
         for (int i = 0; i < 8; i++) begin
            ea[i] = RW'({$urandom, $urandom});
            eb[i] = RW'({$urandom, $urandom});
         end
         ea[0] = '0;
         eb[0] = '1;
         repeat (2) @(posedge clk);
         #1;
         wrst       = 1'b0;
         rbus.a     = ea[0];
         rbus.b     = eb[0];
         rbus.start = 1'b1;
         k = 0; last = 0; cyc = 0;
         while (k < 8 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rbus.done) begin
               check($sformatf("w%0d_diff%0d", RW, k), 64'(rbus.diff), 64'(RW'(ea[k] - eb[k])));
               check($sformatf("w%0d_bout%0d", RW, k), 64'(rbus.bout), 64'(ea[k] < eb[k]));
               if (k > 0) check($sformatf("w%0d_spacing%0d", RW, k), 64'(cyc - last), 64'(RW + 1));
               last = cyc;
               k++;
               if (k < 8) begin
                  rbus.a = ea[k];
                  rbus.b = eb[k];
               end else begin
                  rbus.start = 1'b0;
               end
            end
         end
         check($sformatf("w%0d_jobs_done", RW), 64'(k), 64'd8);
         fin = 1'b1;
      end
   end

   initial begin
      int           lat, busy_n, ndone;
      logic [W-1:0] dacc, got;

      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
      vecs[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
      vecs[6] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
      vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 8'h55;
      bus.b     = 8'h11;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_diff", 64'(bus.diff), 64'd0);
      check("reset_bout", 64'(bus.bout), 64'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check("reset_ovf", 64'(bus.ovf), 64'd0);
`endif
      bus.start = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, lat, busy_n, dacc);
         check($sformatf("v%0d_diff_clear", i), 64'(dacc), 64'd0);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(W));
         check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'(W));
         check($sformatf("v%0d_diff", i), 64'(bus.diff), 64'(vecs[i].diff));
         check($sformatf("v%0d_bout", i), 64'(bus.bout), 64'(vecs[i].bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
         check($sformatf("v%0d_ovf", i), 64'(bus.ovf), 64'(vecs[i].ovf));
`endif
         @(posedge clk);
         #1;
         check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
         check($sformatf("v%0d_diff_hold", i), 64'(bus.diff), 64'(vecs[i].diff));
      end

      // start pulsed mid-run must be ignored
      bus.a = 8'h05; bus.b = 8'h03; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.a = 8'h10; bus.b = 8'h01; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      ndone = 0;
      got   = '0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            ndone++;
            got = bus.diff;
         end
      end
      check("ignored_start_diff", 64'(got), 64'h02);
      check("ignored_start_done_count", 64'(ndone), 64'd1);

      // reset mid-run aborts
      bus.a = 8'hF0; bus.b = 8'h0F; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_diff", 64'(bus.diff), 64'd0);
      check("abort_bout", 64'(bus.bout), 64'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      check("abort_no_done", 64'(ndone), 64'd0);
      do_op(8'h37, 8'h15, lat, busy_n, dacc);
      check("after_abort_latency", 64'(lat), 64'(W));
      check("after_abort_diff", 64'(bus.diff), 64'h22);
      check("after_abort_bout", 64'(bus.bout), 64'd0);

      for (int i = 0; i < 2000; i++) begin
         if (g_rand[0].fin && g_rand[1].fin && g_rand[2].fin) break;
         @(posedge clk);
      end
      check("random_blocks_finished",
            64'(g_rand[0].fin && g_rand[1].fin && g_rand[2].fin), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
